// File: rtl/reg_writeback_pkg.sv
// rtl/reg_writeback_pkg.sv - shared types and constants for the write-back stage
package reg_writeback_pkg;

  localparam logic [3:0] REG_PC = 4'd15;

  // NZCV bit positions within a 4-bit flags value
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        reg_we;
    logic        flags_we;
    logic [3:0]  flags;
  } wb_entry_t;

  // Which source wins when both slots hold a register write
  typedef enum logic {
    PICK_LD  = 1'b0,
    PICK_ALU = 1'b1
  } rr_pick_t;

  function automatic logic is_pc(input wb_entry_t e);
    return e.rd == REG_PC;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - issue, result and register-file signals of the write-back stage
interface reg_writeback_if #(
  parameter int NREGS = 15
);
  logic             stall;
  logic             iss_valid;
  logic [3:0]       iss_rd;
  logic             iss_ready;
  logic [NREGS-1:0] pending;
  logic             alu_valid;
  logic             alu_ready;
  logic [3:0]       alu_rd;
  logic [31:0]      alu_data;
  logic             alu_reg_we;
  logic             alu_flags_we;
  logic [3:0]       alu_flags;
  logic             ld_valid;
  logic             ld_ready;
  logic [3:0]       ld_rd;
  logic [31:0]      ld_data;
  logic             rf_not_enable;
  logic             rf_reg_we;
  logic             rf_flags_we;
  logic [3:0]       rf_sel_in;
  logic [31:0]      rf_in_reg;
  logic [3:0]       rf_in_flags;
  logic             pc_wr_valid;
  logic [31:0]      pc_wr_data;

  // Pipeline side: drives issue and results, observes the write port
  modport master (
    output stall, iss_valid, iss_rd,
    output alu_valid, alu_rd, alu_data, alu_reg_we, alu_flags_we, alu_flags,
    output ld_valid, ld_rd, ld_data,
    input  iss_ready, pending, alu_ready, ld_ready,
    input  rf_not_enable, rf_reg_we, rf_flags_we, rf_sel_in, rf_in_reg, rf_in_flags,
    input  pc_wr_valid, pc_wr_data
  );

  // Write-back stage side
  modport slave (
    input  stall, iss_valid, iss_rd,
    input  alu_valid, alu_rd, alu_data, alu_reg_we, alu_flags_we, alu_flags,
    input  ld_valid, ld_rd, ld_data,
    output iss_ready, pending, alu_ready, ld_ready,
    output rf_not_enable, rf_reg_we, rf_flags_we, rf_sel_in, rf_in_reg, rf_in_flags,
    output pc_wr_valid, pc_wr_data
  );

endinterface

// File: rtl/reg_writeback_slot.sv
// rtl/reg_writeback_slot.sv - one-entry valid/ready holding register with drain input
module reg_writeback_slot
  import reg_writeback_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      in_valid,
  input  wb_entry_t in_entry,
  output logic      in_ready,
  input  logic      drain,
  output logic      full,
  output wb_entry_t entry
);

  // A slot that empties this cycle can take a new entry on the same edge
  assign in_ready = !full || drain;

  // Load on accept, otherwise empty when the arbiter drains the entry
  always_ff @(posedge clock) begin
    if (reset) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (in_valid && in_ready) begin
      full  <= 1'b1;
      entry <= in_entry;
    end else if (drain) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - write-back stage: result slots, drain arbiter and pending-write scoreboard
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int NREGS    = 15,
  parameter bit RR_START = 1'b0
) (
  input logic           clock,
  input logic           reset,
  reg_writeback_if.slave bus
);

  wb_entry_t alu_in, ld_in, alu_e, ld_e, reg_src;
  logic      alu_full, ld_full, alu_drain, ld_drain;
  logic      alu_reg, conflict, reg_src_valid;
  rr_pick_t  rr_q;
  logic [15:0] pend_q, set_mask, clr_mask;

  // Pack incoming results; loads always write a register and never flags
  always_comb begin
    alu_in          = '0;
    alu_in.rd       = bus.alu_rd;
    alu_in.data     = bus.alu_data;
    alu_in.reg_we   = bus.alu_reg_we;
    alu_in.flags_we = bus.alu_flags_we;
    alu_in.flags    = bus.alu_flags;
    ld_in           = '0;
    ld_in.rd        = bus.ld_rd;
    ld_in.data      = bus.ld_data;
    ld_in.reg_we    = 1'b1;
  end

  reg_writeback_slot u_alu_slot (
    .clock    (clock),
    .reset    (reset),
    .in_valid (bus.alu_valid),
    .in_entry (alu_in),
    .in_ready (bus.alu_ready),
    .drain    (alu_drain),
    .full     (alu_full),
    .entry    (alu_e)
  );

  reg_writeback_slot u_ld_slot (
    .clock    (clock),
    .reset    (reset),
    .in_valid (bus.ld_valid),
    .in_entry (ld_in),
    .in_ready (bus.ld_ready),
    .drain    (ld_drain),
    .full     (ld_full),
    .entry    (ld_e)
  );

  // Arbiter: one register write per cycle; a flags-only or no-op ALU entry rides along with a load
  always_comb begin
    alu_drain = 1'b0;
    ld_drain  = 1'b0;
    alu_reg   = alu_full && alu_e.reg_we;
    conflict  = alu_reg && ld_full;
    if (!bus.stall) begin
      if (conflict) begin
        if (rr_q == PICK_ALU) alu_drain = 1'b1;
        else                  ld_drain  = 1'b1;
      end else begin
        ld_drain  = ld_full;
        alu_drain = alu_full;
      end
    end
  end

  // Round-robin pointer only moves when both sources competed for the write port
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= rr_pick_t'(RR_START);
    end else if (!bus.stall && conflict) begin
      rr_q <= (rr_q == PICK_LD) ? PICK_ALU : PICK_LD;
    end
  end

  // Drive the write port straight from the draining slot; r15 goes to the PC output instead
  always_comb begin
    reg_src           = ld_drain ? ld_e : alu_e;
    reg_src_valid     = ld_drain || (alu_drain && alu_e.reg_we);
    bus.rf_reg_we     = reg_src_valid && !is_pc(reg_src);
    bus.pc_wr_valid   = reg_src_valid && is_pc(reg_src);
    bus.rf_flags_we   = alu_drain && alu_e.flags_we;
    bus.rf_sel_in     = bus.rf_reg_we ? reg_src.rd : 4'd0;
    bus.rf_in_reg     = bus.rf_reg_we ? reg_src.data : 32'd0;
    bus.rf_in_flags   = bus.rf_flags_we ? alu_e.flags : 4'd0;
    bus.pc_wr_data    = bus.pc_wr_valid ? reg_src.data : 32'd0;
    bus.rf_not_enable = !(bus.rf_reg_we || bus.rf_flags_we);
  end

  // Scoreboard masks; bit 15 is never set so r15 always reads as ready
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid && bus.iss_ready && (bus.iss_rd != REG_PC)) set_mask[bus.iss_rd] = 1'b1;
    if (bus.rf_reg_we) clr_mask[reg_src.rd] = 1'b1;
  end

  // Pending-write scoreboard: set on issue, cleared at the end of the write cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q | set_mask) & ~clr_mask;
    end
  end

  assign bus.iss_ready = !pend_q[bus.iss_rd];
  assign bus.pending   = pend_q[NREGS-1:0];

endmodule
